// File: rtl/mips_multicycle_alu.sv
// Clocked EX-stage ALU: single-cycle ops register their result; mult/divu iterate into HI/LO.
// Define ALU_SIGNED_MULDIV_EN for two's-complement mult/div and signed slt.
module mips_multicycle_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] imm_ext,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             div_by_zero
);

  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpDivu = 4'b0011;
  localparam logic [3:0] OpBne  = 4'b0100;
  localparam logic [3:0] OpSll  = 4'b0101;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpSrl  = 4'b1000;
  localparam logic [3:0] OpNot  = 4'b1001;
  localparam logic [3:0] OpAnd  = 4'b1011;
  localparam logic [3:0] OpBeq  = 4'b1100;
  localparam logic [3:0] OpMfhi = 4'b1101;
  localparam logic [3:0] OpMflo = 4'b1110;
  localparam logic [3:0] OpMult = 4'b1111;

  localparam logic [SHW:0] LastCnt = (SHW + 1)'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StIter, StFin} state_e;

  state_e           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;

  logic             sign_a, sign_b, slt_lt;
  logic [WIDTH-1:0] a_mag, b_mag;

`ifdef ALU_SIGNED_MULDIV_EN
  assign sign_a = operand_a[WIDTH-1];
  assign sign_b = operand_b[WIDTH-1];
  assign slt_lt = $signed(operand_a) < $signed(operand_b);
`else
  assign sign_a = 1'b0;
  assign sign_b = 1'b0;
  assign slt_lt = operand_a < operand_b;
`endif

  assign a_mag = sign_a ? -operand_a : operand_a;
  assign b_mag = sign_b ? -operand_b : operand_b;

  // Shift-add multiply: acc:mq holds the partial product, multiplier drains out of mq.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc, mul_mq;
  // Restoring divide: acc is the running remainder, dividend bits shift out of mq.
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] div_acc, div_mq;
  logic [WIDTH-1:0] step_acc, step_mq;

  assign mul_sum   = {1'b0, acc_q} + {1'b0, (mq_q[0] ? mag_q : '0)};
  assign mul_acc   = mul_sum[WIDTH:1];
  assign mul_mq    = {mul_sum[0], mq_q[WIDTH-1:1]};
  assign div_shift = {acc_q, mq_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mag_q};
  assign div_ok    = ~div_diff[WIDTH];
  assign div_acc   = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_mq    = {mq_q[WIDTH-2:0], div_ok};
  assign step_acc  = is_div_q ? div_acc : mul_acc;
  assign step_mq   = is_div_q ? div_mq : mul_mq;

  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   fin_hi, fin_lo;

  always_comb begin
    prod_raw = {step_acc, step_mq};
    prod_fix = neg_q ? -prod_raw : prod_raw;
    if (is_div_q) begin
      fin_lo = neg_q ? -step_mq : step_mq;
      fin_hi = rem_neg_q ? -step_acc : step_acc;
    end else begin
      fin_lo = prod_fix[WIDTH-1:0];
      fin_hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  logic [WIDTH-1:0] single_res;

  always_comb begin
    single_res = '0;
    case (alu_ctrl)
      OpAdd:   single_res = operand_a + operand_b;
      OpSub:   single_res = operand_a - operand_b;
      OpOr:    single_res = operand_a | operand_b;
      OpAnd:   single_res = operand_a & operand_b;
      OpNot:   single_res = ~operand_a;
      OpSlt:   single_res = {{(WIDTH - 1){1'b0}}, slt_lt};
      OpSll:   single_res = operand_a << shamt;
      OpSrl:   single_res = operand_a >> shamt;
      OpBeq:   single_res = (operand_a == operand_b) ? imm_ext : '0;
      OpBne:   single_res = (operand_a != operand_b) ? imm_ext : '0;
      OpMfhi:  single_res = hi_q;
      OpMflo:  single_res = lo_q;
      default: single_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    mag_d     = mag_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    zero_d    = zero_q;
    dbz_d     = dbz_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          dbz_d = 1'b0;
          if (alu_ctrl == OpMult || (alu_ctrl == OpDivu && operand_b != '0)) begin
            state_d  = StIter;
            cnt_d    = '0;
            acc_d    = '0;
            is_div_d = (alu_ctrl == OpDivu);
            neg_d    = sign_a ^ sign_b;
            if (alu_ctrl == OpDivu) begin
              mq_d      = a_mag;
              mag_d     = b_mag;
              rem_neg_d = sign_a;
            end else begin
              mq_d      = b_mag;
              mag_d     = a_mag;
              rem_neg_d = 1'b0;
            end
          end else if (alu_ctrl == OpDivu) begin
            state_d  = StFin;
            lo_d     = '1;
            hi_d     = operand_a;
            result_d = '1;
            zero_d   = 1'b0;
            dbz_d    = 1'b1;
          end else begin
            state_d  = StFin;
            result_d = single_res;
            zero_d   = (single_res == '0);
          end
        end
      end
      StIter: begin
        acc_d = step_acc;
        mq_d  = step_mq;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d  = StFin;
          hi_d     = fin_hi;
          lo_d     = fin_lo;
          result_d = fin_lo;
          zero_d   = (fin_lo == '0);
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      mag_q     <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      zero_q    <= 1'b1;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      mag_q     <= mag_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      zero_q    <= zero_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q == StIter);
  assign done        = (state_q == StFin);
  assign result      = result_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mips_multicycle_alu.sv
// Directed plus randomized bench for mips_multicycle_alu against an arithmetic reference model.
module tb_mips_multicycle_alu;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset, start;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] operand_a, operand_b, imm_ext;
  logic [4:0]   shamt;
  logic         busy, done, zero, div_by_zero;
  logic [W-1:0] result, hi, lo;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] hi_m, lo_m;

  mips_multicycle_alu #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .alu_ctrl(alu_ctrl),
    .operand_a(operand_a), .operand_b(operand_b), .shamt(shamt), .imm_ext(imm_ext),
    .busy(busy), .done(done), .result(result), .hi(hi), .lo(lo), .zero(zero),
    .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on 64-bit integers; updates the modelled HI/LO.
  task automatic model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] sh, input logic [W-1:0] imm,
                       output logic [W-1:0] r, output bit dz, output int lat);
    longint sa, sb, q, m;
    logic [63:0] p;
`ifdef ALU_SIGNED_MULDIV_EN
    sa = longint'($signed(a));
    sb = longint'($signed(b));
`else
    sa = longint'({32'b0, a});
    sb = longint'({32'b0, b});
`endif
    dz = 1'b0;
    lat = 1;
    case (c)
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0001: r = a | b;
      4'b1011: r = a & b;
      4'b1001: r = ~a;
      4'b0111: r = (sa < sb) ? 1 : 0;
      4'b0101: r = a << sh;
      4'b1000: r = a >> sh;
      4'b1100: r = (a == b) ? imm : 0;
      4'b0100: r = (a != b) ? imm : 0;
      4'b1101: r = hi_m;
      4'b1110: r = lo_m;
      4'b1111: begin
        p = sa * sb;
        hi_m = p[63:32];
        lo_m = p[31:0];
        r = lo_m;
        lat = W + 1;
      end
      4'b0011: begin
        if (b == 0) begin
          lo_m = '1;
          hi_m = a;
          r = '1;
          dz = 1'b1;
        end else begin
          q = sa / sb;
          m = sa % sb;
          lo_m = q[31:0];
          hi_m = m[31:0];
          r = lo_m;
          lat = W + 1;
        end
      end
      default: r = 0;
    endcase
  endtask

  task automatic run_op(input string tag, input logic [3:0] c, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [4:0] sh, input logic [W-1:0] imm,
                        input bit hammer);
    logic [W-1:0] r_exp;
    bit dz;
    int lat, cyc, busy_cnt;
    model(c, a, b, sh, imm, r_exp, dz, lat);
    @(negedge clock);
    start = 1'b1;
    alu_ctrl = c;
    operand_a = a;
    operand_b = b;
    shamt = sh;
    imm_ext = imm;
    @(posedge clock);
    cyc = 0;
    busy_cnt = 0;
    while (cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (hammer) begin
        alu_ctrl = 4'b0010;
        operand_a = $urandom;
        operand_b = $urandom;
      end else begin
        start = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
      end
      if (busy) busy_cnt++;
      if (done) break;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'((lat > 1) ? W : 0));
    check({tag, "_result"}, 64'(result), 64'(r_exp));
    check({tag, "_zero"}, 64'(zero), 64'(r_exp == 0));
    check({tag, "_hi"}, 64'(hi), 64'(hi_m));
    check({tag, "_lo"}, 64'(lo), 64'(lo_m));
    check({tag, "_dbz"}, 64'(div_by_zero), 64'(dz));
    if (hammer) begin
      @(negedge clock);
      check({tag, "_start_in_fin_ignored"}, 64'(done), 64'(0));
      start = 1'b0;
    end
  endtask

  initial begin
    logic [3:0] c;
    logic [W-1:0] ra, rb;
    int done_seen;
    reset = 1'b1;
    start = 1'b0;
    alu_ctrl = '0;
    operand_a = '0;
    operand_b = '0;
    shamt = '0;
    imm_ext = '0;
    hi_m = '0;
    lo_m = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_result", 64'(result), 0);
    check("rst_hilo", {hi, lo}, 0);
    check("rst_zero", 64'(zero), 1);
    check("rst_dbz", 64'(div_by_zero), 0);

    run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b0);
    run_op("mult_pow", 4'b1111, 32'h0001_0000, 32'h0001_0000, 5'd0, 32'h0, 1'b0);
    check("mult_pow_hi_const", 64'(hi), 64'h1);
    run_op("divu_100_7", 4'b0011, 32'd100, 32'd7, 5'd0, 32'h0, 1'b0);
    check("divu_lo_const", 64'(lo), 64'd14);
    run_op("mfhi", 4'b1101, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
    check("mfhi_const", 64'(result), 64'd2);
    run_op("div0", 4'b0011, 32'd5, 32'd0, 5'd0, 32'h0, 1'b0);
    run_op("add_after_div0", 4'b0010, 32'd3, 32'd4, 5'd0, 32'h0, 1'b0);
    run_op("mult_hammer", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF1, 5'd0, 32'h0, 1'b1);
    run_op("sll", 4'b0101, 32'h8000_0001, 32'h0, 5'd4, 32'h0, 1'b0);
    run_op("beq_taken", 4'b1100, 32'h55, 32'h55, 5'd0, 32'hFFFF_FFF0, 1'b0);
    run_op("bad_code", 4'b1010, 32'h77, 32'h1, 5'd0, 32'h0, 1'b0);
`ifdef ALU_SIGNED_MULDIV_EN
    run_op("smult", 4'b1111, 32'hFFFF_FFFD, 32'd4, 5'd0, 32'h0, 1'b0);
    check("smult_hi_const", 64'(hi), 64'hFFFF_FFFF);
    check("smult_lo_const", 64'(lo), 64'hFFFF_FFF4);
    run_op("sdiv", 4'b0011, 32'hFFFF_FFF9, 32'd2, 5'd0, 32'h0, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      c = 4'($urandom);
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 1) rb = 32'($urandom_range(0, 9));
      if (i % 7 == 3) rb = ra;
      run_op("rand", c, ra, rb, 5'($urandom), $urandom, 1'b0);
    end

    // Reset in the middle of a mult must abort it without a late done.
    @(negedge clock);
    start = 1'b1;
    alu_ctrl = 4'b1111;
    operand_a = 32'hDEAD_BEEF;
    operand_b = 32'h1234_5678;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    check("midmult_busy", 64'(busy), 1);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    hi_m = '0;
    lo_m = '0;
    check("abort_busy", 64'(busy), 0);
    check("abort_done", 64'(done), 0);
    check("abort_hilo", {hi, lo}, 0);
    check("abort_result", 64'(result), 0);
    check("abort_zero", 64'(zero), 1);
    done_seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) done_seen++;
    end
    check("abort_no_late_done", 64'(done_seen), 0);
    run_op("mflo_after_abort", 4'b1110, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_alu.md
Name: mips_multicycle_alu

Overview:
- Parametrised, clocked successor to the datapath's combinational ALU.
- Single-cycle ALU operations get a registered result.
- Mult/div run iteratively (shift-add / restoring) into architectural HI/LO registers, read back via mfhi/mflo codes.
- Sits in the EX stage; the control unit drives a start/busy/done handshake so the pipeline can stall on long operations.

Parameters:
WIDTH, 32, operand/result width in bits (>= 8, power of 2)
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  op request; accepted only in IDLE
alu_ctrl  in  4  operation code (Behaviour)
operand_a  in  WIDTH  rs value
operand_b  in  WIDTH  rt value
shamt  in  SHW  shift amount
imm_ext  in  WIDTH  sign-extended branch offset
busy  out  1  high while mult/div iterates
done  out  1  one-cycle pulse, result/HI/LO valid
result  out  WIDTH  registered result, held until next done
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
zero  out  1  result == 0, registered with result
div_by_zero  out  1  set with done on divide by 0, cleared on next accepted start

Behaviour:
- Reset (synchronous, priority over everything): state=IDLE; busy, done, div_by_zero=0; result, hi, lo=0; zero=1. Reset mid-operation aborts; HI/LO are not updated.
- Operands and alu_ctrl are captured at acceptance; later input changes have no effect.
- Codes, single-cycle (done exactly 1 cycle after the accepting edge, busy stays 0):
  - 0010 add; 0110 sub (both mod 2^WIDTH, no overflow trap)
  - 0001 bitwise or; 1011 and; 1001 not a
  - 0111 slt (unsigned compare, result 1/0)
  - 0101 sll a by shamt; 1000 srl a by shamt (zero fill)
  - 1100 beq: imm_ext if a==b else 0
  - 0100 bne: imm_ext if a!=b else 0
  - 1101 mfhi: result=hi; 1110 mflo: result=lo
  - Any other code: result=0, done still pulses.
- Multi-cycle mult (1111):
  - busy=1 from the cycle after acceptance for WIDTH cycles; done pulses on cycle WIDTH+1 with busy=0.
  - {hi,lo} = a*b, 2*WIDTH-bit product; result=lo.
- Multi-cycle divu (0011):
  - Same timing as mult; lo=a/b, hi=a%b, result=lo.
  - If b==0: no iteration; done after 1 cycle; lo=all ones, hi=a, result=all ones, div_by_zero=1.
- FSM: IDLE -(start, single-cycle op)-> FIN; IDLE -(start, mult/div, b!=0 or mult)-> ITER; ITER -(counter==WIDTH-1)-> FIN; FIN -> IDLE (done=1 in FIN only).
- Iteration counter is SHW+1 bits, cleared on entry to ITER.
- start while not IDLE is ignored (no queueing). start in FIN is also ignored, so back-to-back ops are spaced 2 cycles apart.
- HI/LO are written only on mult/div completion; all other ops leave them unchanged.
- result and zero are updated only in FIN.

Optional Feature:
- Macro ALU_SIGNED_MULDIV_EN.
- Defined:
  - Mult and div treat operands as two's complement. Magnitudes are converted at acceptance and signs fixed at FIN.
  - Remainder takes the sign of the dividend; quotient is negated when the operand signs differ.
  - slt becomes a signed compare.
  - Latency unchanged.
- Undefined: all arithmetic is unsigned, as listed above.

Test Plan:
- reset high 2 cycles while busy mid-mult -> next cycle: busy=0, done=0, hi=lo=result=0, zero=1; no late done.
- start, add, a=0xFFFFFFFF, b=1 -> one cycle later done=1, result=0, zero=1, busy never 1.
- start, mult, a=0x00010000, b=0x00010000 -> busy 32 cycles, done at cycle 33, hi=0x00000001, lo=0, result=0.
- start, divu, a=100, b=7 -> done at cycle 33, lo=14, hi=2; then mfhi -> result=2 one cycle after start.
- start, divu, b=0, a=5 -> done after 1 cycle, div_by_zero=1, lo=0xFFFFFFFF, hi=5; the next accepted add clears div_by_zero.
- start re-asserted every cycle during a mult -> only the first accepted; with the macro defined, mult a=-3 (0xFFFFFFFD), b=4 -> hi=0xFFFFFFFF, lo=0xFFFFFFF4.
